burst_mem_port: RTL and testbench
=================================

Name: burst_mem_port

Overview:
- Memory-controller front end sitting directly downstream of the cache controller.
- Accepts its burst commands (RW, byte address, burst length) into a command queue, buffers write-back data in a write queue, and returns read data through a first-word-fall-through read queue.
- A backend FSM turns each command into single-word requests on a simple req/gnt external memory bus with in-order read returns.

Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of 8.
- OAWIDTH, 32, byte-address width.
- CMD_DEPTH, 4, command queue entries; power of 2.
- DATA_DEPTH, 64, entries in each of the write and read queues; power of 2; must be ≥ the cache NUM_BURST_LEN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_cmdRW  in  1  command type: 0 = READ, 1 = WRITE.
- i_cmdEnable  in  1  push {RW, addr, len} into the command queue.
- o_cmdFull  out  1  command queue full.
- i_burstLen  in  16  burst length in words.
- i_initial_algnAddr  in  OAWIDTH  byte start address.
- i_wrEnable  in  1  push i_wrData into the write queue.
- i_wrData  in  DWIDTH  write data.
- o_wrEmpty  out  1  write queue empty.
- i_rdEnable  in  1  pop the read queue.
- o_rdData  out  DWIDTH  read-queue head (FWFT).
- o_rdEmpty  out  1  read queue empty.
- o_memReq  out  1  memory request valid.
- o_memWe  out  1  1 = write request.
- o_memAddr  out  OAWIDTH  request byte address.
- o_memWdata  out  DWIDTH  write data.
- i_memGnt  in  1  request accepted this cycle when o_memReq is high.
- i_memRvalid  in  1  read data returned, in order.
- i_memRdata  in  DWIDTH  returned read data.
- o_idle  out  1  FSM in IDLE and command queue empty.
- o_error  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - All queues flushed.
  - o_cmdFull = 0, o_wrEmpty = 1, o_rdEmpty = 1, o_rdData = 0.
  - o_memReq = 0, o_memWe = 0, o_memAddr = 0, o_memWdata = 0.
  - o_idle = 1, o_error = 0.
- Reset mid-burst: aborts immediately and asynchronously; outstanding read returns arriving after reset release are discarded.
- Queues:
  - Pushes and pops take effect on the clock edge; flags update the next cycle.
  - Simultaneous push and pop is legal at any occupancy, including full and empty, and leaves the count unchanged.
  - Push to a full queue or pop of an empty queue is ignored and sets o_error.
  - o_rdEnable from upstream is already gated with !empty.
- Read queue data path:
  - o_rdData is valid whenever !o_rdEmpty.
  - Upstream samples o_rdData in the same cycle it asserts i_rdEnable.
- FSM states: IDLE, WR_BURST, RD_REQ, RD_DRAIN.
- IDLE:
  - If the command queue is non-empty: pop the command, load addr, load remaining = len, go to WR_BURST or RD_REQ.
  - Exception, read commands: the pop waits until read-queue free entries ≥ len.
  - len = 0: command popped, no bus activity, stay in IDLE.
  - len > DATA_DEPTH: command popped and discarded, o_error set.
- WR_BURST:
  - o_memReq = 1 while the write queue is non-empty; o_memWe = 1; o_memWdata = write-queue head.
  - On i_memGnt: pop the write queue, addr += DWIDTH/8, remaining -= 1.
  - After the last grant go to IDLE.
  - Write queue empty mid-burst: o_memReq drops and the FSM stalls; this is not an error.
- RD_REQ:
  - o_memReq = 1, o_memWe = 0.
  - On grant: addr += DWIDTH/8, remaining -= 1, outstanding += 1.
  - After the last grant go to RD_DRAIN.
- Read returns (any state): every i_memRvalid pushes i_memRdata into the read queue and decrements outstanding.
- RD_DRAIN: go to IDLE when outstanding = 0, including any return arriving that same cycle.
- Arithmetic widths:
  - Address adder is OAWIDTH bits and wraps modulo 2^OAWIDTH.
  - remaining and outstanding are 16 bits.
- Grant timing: a grant in the same cycle as the FSM transition is honoured, giving no bubble between words of a burst.
- Throughput: one word per cycle with gnt held high.
- Command latency: first o_memReq occurs 2 cycles after the i_cmdEnable edge, with the command queue previously empty.

Decomposition:
- Package burst_mem_port_pkg holds:
  - FSM state encoding (one-hot, 4 bits).
  - READ/WRITE and ENABLE/DISABLE constants.
  - The command record width: 1 + 16 + OAWIDTH.
- One sub-module, sync_fifo (parameterised width and depth, FWFT, count output), instantiated three times for the command, write and read queues.

Test Plan:
- Write burst: push 4 words 0xA0..0xA3, then write cmd addr 0x100, len 4, gnt tied high → grants at addr 0x100, 0x104, 0x108, 0x10C with data A0..A3; o_wrEmpty = 1 afterwards; o_idle returns to 1.
- Read burst: read cmd addr 0x200, len 8; memory returns 0x200>>2+k with 3-cycle latency → o_rdEmpty falls; 8 FWFT pops yield 0x80..0x87; o_error = 0.
- Command backpressure: 5 cmds pushed with gnt held 0 → o_cmdFull = 1 after the 4th; a 5th push sets o_error; queue order is preserved once gnt is raised.
- Read-space gating: read queue holding 60 of 64, read cmd len 8 → no o_memReq until ≥ 8 entries are free, i.e. after 4 pops.
- Write underflow stall: write cmd len 4 with only 2 words queued → 2 grants, then o_memReq = 0; a later push of 2 words resumes the burst at addr +8; o_error stays 0.
- Reset mid-read: reset asserted after 3 of 8 grants → all outputs at reset values within the same cycle; late i_memRvalid pulses leave o_rdEmpty = 1.

Source files
------------

// File: rtl/burst_mem_port_pkg.sv
// Shared types and constants for the burst memory port.
// FSM one-hot encoding, command fields and the command record width.
package burst_mem_port_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WR_BURST = 4'b0010,
    ST_RD_REQ   = 4'b0100,
    ST_RD_DRAIN = 4'b1000
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;

  localparam int LEN_W = 16;

  function automatic int cmd_width(input int aw);
    return 1 + LEN_W + aw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Ports: push/wdata, pop/rdata (head, 0 when empty), full, empty,
// count, and one-cycle overflow/underflow pulses for ignored ops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Push+pop together is accepted at full (slot is freed
  // this edge) and is a no-op at empty (nothing to pop).
  assign do_push = push && (pop ? !empty : !full);
  assign do_pop  = pop && !empty;

  assign overflow  = push && !pop && full;
  assign underflow = pop && !push && empty;

  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/burst_mem_port.sv
// Burst command front end: command/write/read queues and a backend FSM
// issuing single-word req/gnt bus requests with in-order read returns.
module burst_mem_port
  import burst_mem_port_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int OAWIDTH    = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cmdRW,
  input  logic               i_cmdEnable,
  output logic               o_cmdFull,
  input  logic [15:0]        i_burstLen,
  input  logic [OAWIDTH-1:0] i_initial_algnAddr,
  input  logic               i_wrEnable,
  input  logic [DWIDTH-1:0]  i_wrData,
  output logic               o_wrEmpty,
  input  logic               i_rdEnable,
  output logic [DWIDTH-1:0]  o_rdData,
  output logic               o_rdEmpty,
  output logic               o_memReq,
  output logic               o_memWe,
  output logic [OAWIDTH-1:0] o_memAddr,
  output logic [DWIDTH-1:0]  o_memWdata,
  input  logic               i_memGnt,
  input  logic               i_memRvalid,
  input  logic [DWIDTH-1:0]  i_memRdata,
  output logic               o_idle,
  output logic               o_error
);

  localparam int CMD_W = cmd_width(OAWIDTH);
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int DCW   = $clog2(DATA_DEPTH) + 1;

  localparam logic [OAWIDTH-1:0] STEP = OAWIDTH'(DWIDTH / 8);
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DATA_DEPTH);

  state_t             state, state_n;
  logic [OAWIDTH-1:0] addr, addr_n;
  logic [LEN_W-1:0]   remaining, rem_n;
  logic [LEN_W-1:0]   outstanding, out_n;
  logic               err;

  logic [CMD_W-1:0]   cmd_head;
  logic               cmd_empty;
  logic               cmd_pop;
  logic [CCW-1:0]     cmd_count;
  logic               cmd_ovf, cmd_udf;
  logic               cmd_rw;
  logic [LEN_W-1:0]   cmd_len;
  logic [OAWIDTH-1:0] cmd_addr;

  logic [DWIDTH-1:0]  wr_head;
  logic               wr_pop;
  logic               wr_full;
  logic [DCW-1:0]     wr_count;
  logic               wr_ovf, wr_udf;

  logic               rd_full;
  logic [DCW-1:0]     rd_count;
  logic               rd_ovf, rd_udf;
  logic               rd_accept;
  logic               rd_grant;
  logic [LEN_W:0]     free;
  logic               drain_done;
  logic               len_err;
  logic               req;
  logic               we;
  logic               unused_ok;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_q (
    .clk       (clk),
    .reset     (reset),
    .push      (i_cmdEnable),
    .pop       (cmd_pop),
    .wdata     ({i_cmdRW, i_burstLen, i_initial_algnAddr}),
    .rdata     (cmd_head),
    .full      (o_cmdFull),
    .empty     (cmd_empty),
    .count     (cmd_count),
    .overflow  (cmd_ovf),
    .underflow (cmd_udf)
  );

  sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DATA_DEPTH)) u_wr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (i_wrEnable),
    .pop       (wr_pop),
    .wdata     (i_wrData),
    .rdata     (wr_head),
    .full      (wr_full),
    .empty     (o_wrEmpty),
    .count     (wr_count),
    .overflow  (wr_ovf),
    .underflow (wr_udf)
  );

  sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DATA_DEPTH)) u_rd_q (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_accept),
    .pop       (i_rdEnable),
    .wdata     (i_memRdata),
    .rdata     (o_rdData),
    .full      (rd_full),
    .empty     (o_rdEmpty),
    .count     (rd_count),
    .overflow  (rd_ovf),
    .underflow (rd_udf)
  );

  assign unused_ok = ^{cmd_count, wr_count, wr_full, rd_full};

  assign cmd_rw   = cmd_head[CMD_W-1];
  assign cmd_len  = cmd_head[CMD_W-2 -: LEN_W];
  assign cmd_addr = cmd_head[OAWIDTH-1:0];

  // Returns with nothing outstanding belong to a burst killed
  // by reset and are dropped.
  assign rd_accept = i_memRvalid && (outstanding != '0);

  assign free = DEPTH_L - (LEN_W + 1)'(rd_count);

  assign out_n = outstanding
               + LEN_W'(rd_grant)
               - LEN_W'(rd_accept);

  assign drain_done = (outstanding == '0) ||
                      (outstanding == LEN_W'(1) && rd_accept);

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    rem_n    = remaining;
    cmd_pop  = DISABLE;
    wr_pop   = DISABLE;
    rd_grant = DISABLE;
    len_err  = DISABLE;
    req      = DISABLE;
    we       = DISABLE;
    case (state)
      ST_IDLE: begin
        if (!cmd_empty) begin
          if (cmd_len == '0) begin
            cmd_pop = ENABLE;
          end else if ({1'b0, cmd_len} > DEPTH_L) begin
            cmd_pop = ENABLE;
            len_err = ENABLE;
          end else if (cmd_rw == CMD_WRITE) begin
            cmd_pop = ENABLE;
            addr_n  = cmd_addr;
            rem_n   = cmd_len;
            state_n = ST_WR_BURST;
          end else if (cmd_rw == CMD_READ &&
                       {1'b0, cmd_len} <= free) begin
            cmd_pop = ENABLE;
            addr_n  = cmd_addr;
            rem_n   = cmd_len;
            state_n = ST_RD_REQ;
          end
        end
      end
      ST_WR_BURST: begin
        req = !o_wrEmpty;
        we  = ENABLE;
        if (req && i_memGnt) begin
          wr_pop = ENABLE;
          addr_n = addr + STEP;
          rem_n  = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_n = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        req = ENABLE;
        if (i_memGnt) begin
          rd_grant = ENABLE;
          addr_n   = addr + STEP;
          rem_n    = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_n = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if (drain_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      remaining   <= rem_n;
      outstanding <= out_n;
      err         <= err | len_err
                   | cmd_ovf | cmd_udf
                   | wr_ovf  | wr_udf
                   | rd_ovf  | rd_udf;
    end
  end

  assign o_memReq   = req;
  assign o_memWe    = we;
  assign o_memAddr  = addr;
  assign o_memWdata = (state == ST_WR_BURST) ? wr_head : '0;
  assign o_idle     = (state == ST_IDLE) && cmd_empty;
  assign o_error    = err;

endmodule

// File: tb/tb_burst_mem_port.sv
// Directed self-checking bench for burst_mem_port.
// Memory model grants per i_memGnt and returns addr>>2 after 3 cycles.
module tb_burst_mem_port;

  logic        clk;
  logic        reset;
  logic        i_cmdRW;
  logic        i_cmdEnable;
  logic        o_cmdFull;
  logic [15:0] i_burstLen;
  logic [31:0] i_initial_algnAddr;
  logic        i_wrEnable;
  logic [31:0] i_wrData;
  logic        o_wrEmpty;
  logic        i_rdEnable;
  logic [31:0] o_rdData;
  logic        o_rdEmpty;
  logic        o_memReq;
  logic        o_memWe;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic        i_memGnt;
  logic        i_memRvalid;
  logic [31:0] i_memRdata;
  logic        o_idle;
  logic        o_error;

  int checks = 0;
  int fails  = 0;

  logic [2:0]  rv_pipe = '0;
  logic [31:0] rd_pipe [3];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        log_we   [$];
  int          late_rv = 0;

  burst_mem_port dut (
    .clk                (clk),
    .reset              (reset),
    .i_cmdRW            (i_cmdRW),
    .i_cmdEnable        (i_cmdEnable),
    .o_cmdFull          (o_cmdFull),
    .i_burstLen         (i_burstLen),
    .i_initial_algnAddr (i_initial_algnAddr),
    .i_wrEnable         (i_wrEnable),
    .i_wrData           (i_wrData),
    .o_wrEmpty          (o_wrEmpty),
    .i_rdEnable         (i_rdEnable),
    .o_rdData           (o_rdData),
    .o_rdEmpty          (o_rdEmpty),
    .o_memReq           (o_memReq),
    .o_memWe            (o_memWe),
    .o_memAddr          (o_memAddr),
    .o_memWdata         (o_memWdata),
    .i_memGnt           (i_memGnt),
    .i_memRvalid        (i_memRvalid),
    .i_memRdata         (i_memRdata),
    .o_idle             (o_idle),
    .o_error            (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_memRvalid = rv_pipe[2];
  assign i_memRdata  = rd_pipe[2];

  always @(posedge clk) begin
    rv_pipe    <= {rv_pipe[1:0], o_memReq & i_memGnt & ~o_memWe};
    rd_pipe[0] <= o_memAddr >> 2;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
    if (o_memReq && i_memGnt) begin
      log_addr.push_back(o_memAddr);
      log_data.push_back(o_memWdata);
      log_we.push_back(o_memWe);
    end
    if (i_memRvalid && !reset) late_rv++;
  end

  task automatic clear_inputs();
    i_cmdRW = 0; i_cmdEnable = 0; i_burstLen = 0;
    i_initial_algnAddr = 0; i_wrEnable = 0; i_wrData = 0;
    i_rdEnable = 0; i_memGnt = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    log_addr.delete(); log_data.delete(); log_we.delete();
    late_rv = 0;
  endtask

  task automatic push_wr(input logic [31:0] d);
    i_wrEnable = 1; i_wrData = d;
    @(negedge clk);
    i_wrEnable = 0;
  endtask

  task automatic push_cmd(input logic rw, input logic [31:0] a,
                          input logic [15:0] len);
    i_cmdRW = rw; i_initial_algnAddr = a; i_burstLen = len;
    i_cmdEnable = 1;
    @(negedge clk);
    i_cmdEnable = 0;
  endtask

  task automatic pop_rd();
    i_rdEnable = 1;
    @(negedge clk);
    i_rdEnable = 0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (o_idle) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    reset = 1;
    clear_inputs();
    @(negedge clk);
    flags = {o_cmdFull, o_wrEmpty, o_rdEmpty, o_memReq,
             o_memWe, o_idle, o_error};
    checks++;
    if (flags !== 7'b0110010) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0110010", flags);
    end
    checks++;
    if ({o_rdData, o_memAddr, o_memWdata} !== 96'h0) begin
      fails++;
      $display("FAIL reset_buses: got %h %h %h expected 0",
               o_rdData, o_memAddr, o_memWdata);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    bit ok;
    do_reset();
    i_memGnt = 1;
    for (int k = 0; k < 4; k++) push_wr(32'hA0 + k);
    push_cmd(1'b1, 32'h100, 16'd4);
    checks++;
    if (o_memReq !== 1'b0) begin
      fails++;
      $display("FAIL wr_latency_early: got %b expected 0", o_memReq);
    end
    @(negedge clk);
    checks++;
    if ({o_memReq, o_memWe, o_memAddr} !== {2'b11, 32'h100}) begin
      fails++;
      $display("FAIL wr_first_req: got %b%b %h expected 11 100",
               o_memReq, o_memWe, o_memAddr);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL wr_idle_timeout: got 0 expected 1");
    end
    checks++;
    if (log_addr.size() != 4) begin
      fails++;
      $display("FAIL wr_grants: got %0d expected 4", log_addr.size());
    end
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      checks++;
      if ({log_we[k], log_addr[k], log_data[k]} !==
          {1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k)}) begin
        fails++;
        $display("FAIL wr_beat[%0d]: got %b %h %h expected 1 %h %h",
                 k, log_we[k], log_addr[k], log_data[k],
                 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      end
    end
    checks++;
    if ({o_wrEmpty, o_idle, o_error} !== 3'b110) begin
      fails++;
      $display("FAIL wr_end_flags: got %b expected 110",
               {o_wrEmpty, o_idle, o_error});
    end
  endtask

  task automatic test_read_burst();
    bit ok;
    do_reset();
    i_memGnt = 1;
    push_cmd(1'b0, 32'h200, 16'd8);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (!o_rdEmpty) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL rd_empty_fall: got 1 expected 0");
    end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL rd_idle_timeout: got 0 expected 1");
    end
    checks++;
    if (log_addr.size() != 8) begin
      fails++;
      $display("FAIL rd_grants: got %0d expected 8", log_addr.size());
    end
    for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
      checks++;
      if ({log_we[k], log_addr[k]} !== {1'b0, 32'h200 + 32'(4 * k)})
      begin
        fails++;
        $display("FAIL rd_req[%0d]: got %b %h expected 0 %h",
                 k, log_we[k], log_addr[k], 32'h200 + 32'(4 * k));
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({o_rdEmpty, o_rdData} !== {1'b0, 32'h80 + 32'(k)}) begin
        fails++;
        $display("FAIL rd_pop[%0d]: got %b %h expected 0 %h",
                 k, o_rdEmpty, o_rdData, 32'h80 + 32'(k));
      end
      pop_rd();
    end
    checks++;
    if ({o_rdEmpty, o_error} !== 2'b10) begin
      fails++;
      $display("FAIL rd_end_flags: got %b expected 10",
               {o_rdEmpty, o_error});
    end
  endtask

  task automatic test_cmd_backpressure();
    bit ok;
    logic [31:0] exp_a;
    do_reset();
    i_memGnt = 0;
    push_cmd(1'b0, 32'h300, 16'd1);
    @(negedge clk);
    push_cmd(1'b0, 32'h310, 16'd1);
    push_cmd(1'b0, 32'h320, 16'd1);
    push_cmd(1'b0, 32'h330, 16'd1);
    checks++;
    if (o_cmdFull !== 1'b0) begin
      fails++;
      $display("FAIL bp_full_at3: got %b expected 0", o_cmdFull);
    end
    push_cmd(1'b0, 32'h340, 16'd1);
    checks++;
    if ({o_cmdFull, o_error} !== 2'b10) begin
      fails++;
      $display("FAIL bp_full_at4: got %b expected 10",
               {o_cmdFull, o_error});
    end
    push_cmd(1'b0, 32'h350, 16'd1);
    checks++;
    if ({o_cmdFull, o_error} !== 2'b11) begin
      fails++;
      $display("FAIL bp_overflow: got %b expected 11",
               {o_cmdFull, o_error});
    end
    i_memGnt = 1;
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_idle_timeout: got 0 expected 1");
    end
    checks++;
    if (log_addr.size() != 5) begin
      fails++;
      $display("FAIL bp_grants: got %0d expected 5", log_addr.size());
    end
    for (int k = 0; k < 5 && k < log_addr.size(); k++) begin
      exp_a = 32'h300 + 32'(16 * k);
      checks++;
      if (log_addr[k] !== exp_a) begin
        fails++;
        $display("FAIL bp_order[%0d]: got %h expected %h",
                 k, log_addr[k], exp_a);
      end
    end
    checks++;
    if (o_rdData !== 32'hC0) begin
      fails++;
      $display("FAIL bp_rd_head: got %h expected c0", o_rdData);
    end
  endtask

  task automatic test_read_gating();
    bit ok;
    int hits;
    do_reset();
    i_memGnt = 1;
    push_cmd(1'b0, 32'h1000, 16'd60);
    wait_idle(300, ok);
    checks++;
    if (!ok || o_rdEmpty) begin
      fails++;
      $display("FAIL gate_fill: got idle=%b empty=%b expected 1 0",
               o_idle, o_rdEmpty);
    end
    log_addr.delete(); log_data.delete(); log_we.delete();
    push_cmd(1'b0, 32'h2000, 16'd8);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_memReq) hits++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_rdData !== 32'h400 + 32'(k)) begin
        fails++;
        $display("FAIL gate_pop[%0d]: got %h expected %h",
                 k, o_rdData, 32'h400 + 32'(k));
      end
      pop_rd();
    end
    for (int i = 0; i < 3; i++) begin
      if (o_memReq) hits++;
      @(negedge clk);
    end
    pop_rd();
    if (o_memReq) hits++;
    checks++;
    if (hits != 0) begin
      fails++;
      $display("FAIL gate_blocked: got %0d req cycles expected 0", hits);
    end
    @(negedge clk);
    checks++;
    if ({o_memReq, o_memAddr} !== {1'b1, 32'h2000}) begin
      fails++;
      $display("FAIL gate_release: got %b %h expected 1 2000",
               o_memReq, o_memAddr);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || o_error || log_addr.size() != 8) begin
      fails++;
      $display("FAIL gate_end: got idle=%b err=%b n=%0d expected 1 0 8",
               o_idle, o_error, log_addr.size());
    end
  endtask

  task automatic test_wr_underflow();
    bit ok;
    do_reset();
    i_memGnt = 1;
    push_wr(32'hB0);
    push_wr(32'hB1);
    push_cmd(1'b1, 32'h400, 16'd4);
    repeat (8) @(negedge clk);
    checks++;
    if (log_addr.size() != 2) begin
      fails++;
      $display("FAIL uf_grants: got %0d expected 2", log_addr.size());
    end
    checks++;
    if ({o_memReq, o_idle, o_error} !== 3'b000) begin
      fails++;
      $display("FAIL uf_stall: got %b expected 000",
               {o_memReq, o_idle, o_error});
    end
    push_wr(32'hB2);
    push_wr(32'hB3);
    wait_idle(50, ok);
    checks++;
    if (!ok || log_addr.size() != 4) begin
      fails++;
      $display("FAIL uf_resume: got idle=%b n=%0d expected 1 4",
               o_idle, log_addr.size());
    end
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      checks++;
      if ({log_addr[k], log_data[k]} !==
          {32'h400 + 32'(4 * k), 32'hB0 + 32'(k)}) begin
        fails++;
        $display("FAIL uf_beat[%0d]: got %h %h expected %h %h",
                 k, log_addr[k], log_data[k],
                 32'h400 + 32'(4 * k), 32'hB0 + 32'(k));
      end
    end
    checks++;
    if (o_error !== 1'b0) begin
      fails++;
      $display("FAIL uf_error: got %b expected 0", o_error);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    logic [6:0] flags;
    do_reset();
    i_memGnt = 1;
    push_cmd(1'b0, 32'h500, 16'd8);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (log_addr.size() >= 3) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || log_addr.size() != 3) begin
      fails++;
      $display("FAIL mr_grants: got %0d expected 3", log_addr.size());
    end
    #1 reset = 1;
    #1;
    flags = {o_cmdFull, o_wrEmpty, o_rdEmpty, o_memReq,
             o_memWe, o_idle, o_error};
    checks++;
    if (flags !== 7'b0110010) begin
      fails++;
      $display("FAIL mr_async_flags: got %b expected 0110010", flags);
    end
    checks++;
    if ({o_memAddr, o_memWdata, o_rdData} !== 96'h0) begin
      fails++;
      $display("FAIL mr_async_buses: got %h %h %h expected 0",
               o_memAddr, o_memWdata, o_rdData);
    end
    @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (late_rv != 2) begin
      fails++;
      $display("FAIL mr_late_pulses: got %0d expected 2", late_rv);
    end
    checks++;
    if ({o_rdEmpty, o_idle, o_memReq, o_error} !== 4'b1100) begin
      fails++;
      $display("FAIL mr_discard: got %b expected 1100",
               {o_rdEmpty, o_idle, o_memReq, o_error});
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_write_burst();
    test_read_burst();
    test_cmd_backpressure();
    test_read_gating();
    test_wr_underflow();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
